// File: rtl/rca_bist_ctrl.sv
// BIST sequencer for the 4-bit RCA fault test: clears the TPG, steps NVEC vectors,
// compares each RCA response to a golden sum and compacts responses into a 5-bit MISR.
module rca_bist_ctrl #(
  parameter int WIDTH = 4,
  parameter int NVEC  = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             start,
  input  logic [WIDTH-1:0] at,
  input  logic [WIDTH-1:0] bt,
  input  logic             cint,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic             tpg_init,
  output logic             test,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W:0]   fail_cnt,
  output logic [CNT_W-1:0] first_fail,
  output logic [4:0]       signature,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_vec_idx
);

  // Handshake: start is a level sampled only in IDLE/DONE; done is a one-cycle
  // pulse and pass/fail_cnt/first_fail/signature are valid from done until the next CLEAR.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NVEC - 1);
  localparam logic [CNT_W-1:0] ONE_IDX  = CNT_W'(1);
  localparam logic [4:0]       MISR_SEED = 5'h1F;

  state_t              r_state;
  state_t              w_next;
  logic                r_tpg_init;
  logic                r_test;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [CNT_W:0]      r_fail_cnt;
  logic [CNT_W-1:0]    r_first_fail;
  logic [4:0]          r_sig;
  logic [CNT_W-1:0]    r_vec_idx;

  logic [WIDTH:0]      w_exp;
  logic [WIDTH:0]      w_resp;
  logic                w_mismatch;
  logic [CNT_W:0]      w_fail_cnt_nxt;
  logic [4:0]          w_resp5;
  logic [4:0]          w_sig_nxt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_RUN;
      S_RUN:   if (r_vec_idx == LAST_IDX) w_next = S_DONE;
      S_DONE:  w_next = start ? S_CLEAR : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Golden sum is a zero-extended add so the carry lands in the MSB.
  assign w_exp          = {1'b0, at} + {1'b0, bt} + {{WIDTH{1'b0}}, cint};
  assign w_resp         = {cout_in, sum_in};
  assign w_mismatch     = (w_resp != w_exp);
  assign w_fail_cnt_nxt = r_fail_cnt + {{CNT_W{1'b0}}, w_mismatch};
  assign w_resp5        = 5'(w_resp);
  assign w_sig_nxt      = {r_sig[3:0], r_sig[4]} ^ w_resp5 ^ (r_sig[4] ? 5'b00100 : 5'b00000);

  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_state      <= S_IDLE;
      r_tpg_init   <= 1'b1;
      r_test       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_cnt   <= '0;
      r_first_fail <= '0;
      r_sig        <= MISR_SEED;
      r_vec_idx    <= '0;
    end else begin
      r_state    <= w_next;
      r_tpg_init <= (w_next != S_RUN);
      r_test     <= (w_next == S_CLEAR) || (w_next == S_RUN);
      r_busy     <= (w_next == S_CLEAR) || (w_next == S_RUN);
      r_done     <= (w_next == S_DONE);
      if (w_next == S_CLEAR) begin
        r_pass       <= 1'b0;
        r_fail_cnt   <= '0;
        r_first_fail <= '0;
        r_sig        <= MISR_SEED;
        r_vec_idx    <= '0;
      end else if (r_state == S_RUN) begin
        // vec_idx tracks the TPG count, which wraps at NVEC.
        r_vec_idx <= (r_vec_idx == LAST_IDX) ? '0 : r_vec_idx + ONE_IDX;
        r_sig     <= w_sig_nxt;
        if (w_mismatch) begin
          r_fail_cnt <= w_fail_cnt_nxt;
          if (r_fail_cnt == '0) r_first_fail <= r_vec_idx;
        end
        if (w_next == S_DONE) r_pass <= (w_fail_cnt_nxt == '0);
      end
    end
  end

  assign tpg_init    = r_tpg_init;
  assign test        = r_test;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail_cnt    = r_fail_cnt;
  assign first_fail  = r_first_fail;
  assign signature   = r_sig;
  assign dbg_state   = r_state;
  assign dbg_vec_idx = r_vec_idx;

endmodule

// File: tb/tb_rca_bist_ctrl.sv
// Bench for rca_bist_ctrl: behavioural TPG + RCA with injectable faults, directed
// table of stuck-at cases, hand-written multi-cycle sequences and random fault runs.
module tb_rca_bist_ctrl;

  logic       clk = 1'b0;
  logic       init_n;
  logic       start;
  logic [3:0] at, bt, sum_in;
  logic       cint, cout_in;
  logic       tpg_init, test, busy, done, pass;
  logic [3:0] fail_cnt;
  logic [2:0] first_fail;
  logic [4:0] signature;
  logic [1:0] dbg_state;
  logic [2:0] dbg_vec_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // TPG golden vector table and fault knobs for the RCA model
  logic [3:0] ga [8];
  logic [3:0] gb [8];
  logic       gc [8];
  logic [4:0] flip [8];
  logic [4:0] sa0, sa1;
  logic [2:0] tpg_cnt = 3'd0;
  logic [4:0] gold_now, resp_now;
  int         seen [8];
  int         base [8];

  rca_bist_ctrl #(.WIDTH(4), .NVEC(8), .CNT_W(3)) dut (
    .clk(clk), .init_n(init_n), .start(start),
    .at(at), .bt(bt), .cint(cint),
    .sum_in(sum_in), .cout_in(cout_in),
    .tpg_init(tpg_init), .test(test), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .first_fail(first_fail), .signature(signature),
    .dbg_state(dbg_state), .dbg_vec_idx(dbg_vec_idx)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // TPG: cleared while tpg_init is high, otherwise counts mod 8 every clock
  always @(posedge clk) begin
    if (test && !tpg_init) seen[tpg_cnt] <= seen[tpg_cnt] + 1;
    tpg_cnt <= tpg_init ? 3'd0 : tpg_cnt + 3'd1;
  end

  assign at       = ga[tpg_cnt];
  assign bt       = gb[tpg_cnt];
  assign cint     = gc[tpg_cnt];
  assign gold_now = {1'b0, at} + {1'b0, bt} + {4'b0, cint};
  assign resp_now = ((gold_now & ~sa0) | sa1) ^ flip[tpg_cnt];
  assign {cout_in, sum_in} = resp_now;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference: walk the 8 vectors, count mismatches, divide responses into the MISR.
  task automatic model(output int fc, output int first, output int sig);
    int g, r;
    fc = 0; first = 0; sig = 31;
    for (int i = 0; i < 8; i++) begin
      g = int'(ga[i]) + int'(gb[i]) + int'(gc[i]);
      r = int'(((5'(g) & ~sa0) | sa1) ^ flip[i]);
      if (r != g) begin
        if (fc == 0) first = i;
        fc++;
      end
      sig = ((sig * 2) % 32) ^ ((sig >= 16) ? 5 : 0) ^ r;
    end
  endtask

  // Driver: assert start at a negedge and count negedges until done (bounded).
  task automatic run_bist(input bit hold, input int extra, output int lat, output int busy_bad);
    for (int i = 0; i < 8; i++) base[i] = seen[i];
    start = 1'b1; lat = -1; busy_bad = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      start = hold || (n == extra);
      if (done) begin lat = n; break; end
      if (!busy || !test) busy_bad++;
    end
  endtask

  task automatic check_run(input string tag, input int lat, input int busy_bad,
                           input int efc, input int efirst, input int epass);
    int mfc, mfirst, msig, seen_bad;
    model(mfc, mfirst, msig);
    seen_bad = 0;
    for (int i = 0; i < 8; i++) if (seen[i] - base[i] != 1) seen_bad++;
    chk({tag, " latency"},    lat, 10);
    chk({tag, " busy"},       busy_bad, 0);
    chk({tag, " fail_cnt"},   int'(fail_cnt), efc);
    chk({tag, " first_fail"}, int'(first_fail), efirst);
    chk({tag, " pass"},       int'(pass), epass);
    chk({tag, " signature"},  int'(signature), msig);
    chk({tag, " tpg_seen"},   seen_bad, 0);
  endtask

  typedef struct {
    string      name;
    logic [4:0] s0;
    logic [4:0] s1;
    int         efc;
    int         efirst;
    int         epass;
  } vec_t;

  vec_t tbl [4];
  int lat, bb, mfc, mfirst, msig, ndone;
  logic [4:0] sig_a;

  initial begin
    ga[0]=4'hA; gb[0]=4'hA; gc[0]=1'b1;
    ga[1]=4'hA; gb[1]=4'h5; gc[1]=1'b0;
    ga[2]=4'h5; gb[2]=4'hA; gc[2]=1'b0;
    ga[3]=4'h5; gb[3]=4'h5; gc[3]=1'b0;
    ga[4]=4'h0; gb[4]=4'h0; gc[4]=1'b0;
    ga[5]=4'h0; gb[5]=4'hF; gc[5]=1'b1;
    ga[6]=4'hF; gb[6]=4'h0; gc[6]=1'b1;
    ga[7]=4'hF; gb[7]=4'hF; gc[7]=1'b1;
    for (int i = 0; i < 8; i++) begin flip[i] = 5'd0; seen[i] = 0; end
    sa0 = 5'd0; sa1 = 5'd0;
    tbl[0] = '{"fault_free", 5'b00000, 5'b00000, 0, 0, 1};
    tbl[1] = '{"sum0_sa0",   5'b00001, 5'b00000, 4, 0, 0};
    tbl[2] = '{"sum1_sa0",   5'b00010, 5'b00000, 4, 1, 0};
    tbl[3] = '{"cout_sa0",   5'b10000, 5'b00000, 4, 0, 0};

    init_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst state",      int'(dbg_state), 0);
    chk("rst tpg_init",   int'(tpg_init), 1);
    chk("rst test",       int'(test), 0);
    chk("rst busy",       int'(busy), 0);
    chk("rst done",       int'(done), 0);
    chk("rst pass",       int'(pass), 0);
    chk("rst fail_cnt",   int'(fail_cnt), 0);
    chk("rst first_fail", int'(first_fail), 0);
    chk("rst signature",  int'(signature), 31);
    init_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed stuck-at table
    for (int t = 0; t < 4; t++) begin
      sa0 = tbl[t].s0; sa1 = tbl[t].s1;
      run_bist(1'b0, 0, lat, bb);
      check_run(tbl[t].name, lat, bb, tbl[t].efc, tbl[t].efirst, tbl[t].epass);
      @(negedge clk);
      chk({tbl[t].name, " done_width"}, int'(done), 0);
      chk({tbl[t].name, " hold"}, int'(fail_cnt), tbl[t].efc);
      repeat (2) @(negedge clk);
    end

    // cout stuck-at-0 with start held high: back-to-back runs must match
    sa0 = 5'b10000;
    run_bist(1'b1, 0, lat, bb);
    check_run("b2b_run1", lat, bb, 4, 0, 0);
    sig_a = signature;
    run_bist(1'b0, 0, lat, bb);
    check_run("b2b_run2", lat, bb, 4, 0, 0);
    chk("b2b sig_equal", int'(signature), int'(sig_a));
    repeat (2) @(negedge clk);

    // reset in the middle of RUN at vector 4 aborts with no done
    sa0 = 5'b00001;
    start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort vec_idx", int'(dbg_vec_idx), 4);
    chk("abort fails_before", int'(fail_cnt), 3);
    init_n = 1'b0;
    @(negedge clk);
    chk("abort state",      int'(dbg_state), 0);
    chk("abort busy",       int'(busy), 0);
    chk("abort done",       int'(done), 0);
    chk("abort tpg_init",   int'(tpg_init), 1);
    chk("abort test",       int'(test), 0);
    chk("abort fail_cnt",   int'(fail_cnt), 0);
    chk("abort first_fail", int'(first_fail), 0);
    chk("abort signature",  int'(signature), 31);
    chk("abort pass",       int'(pass), 0);
    init_n = 1'b1;
    ndone = 0;
    repeat (12) begin @(negedge clk); if (done) ndone++; end
    chk("abort no_done", ndone, 0);
    sa0 = 5'd0;
    run_bist(1'b0, 0, lat, bb);
    check_run("after_abort", lat, bb, 0, 0, 1);
    repeat (2) @(negedge clk);

    // extra start pulse during RUN must be ignored
    sa0 = 5'b00010;
    run_bist(1'b0, 5, lat, bb);
    check_run("start_in_run", lat, bb, 4, 1, 0);
    ndone = 0;
    repeat (15) begin @(negedge clk); if (done) ndone++; end
    chk("start_in_run extra_done", ndone, 0);
    chk("start_in_run idle", int'(dbg_state), 0);

    // random fault patterns against the reference model
    for (int r = 0; r < 25; r++) begin
      sa0 = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      sa1 = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      for (int i = 0; i < 8; i++)
        flip[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      model(mfc, mfirst, msig);
      run_bist(1'b0, 0, lat, bb);
      check_run($sformatf("rand%0d", r), lat, bb, mfc, mfirst, (mfc == 0) ? 1 : 0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
